// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and
// multi-cycle multiply stalls, with a saturating stall-cycle counter.
//
// state    | meaning
// ---------+------------------------------------------------------------
// RUN      | normal issue; load-use, branch and multiply start detected
// FLUSH    | second squash cycle after a taken branch
// MUL_WAIT | front end frozen while the multiplier finishes
module hazard_ctrl #(
  parameter int unsigned MUL_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ID_EX_MemRead,
  input  logic [4:0]  ID_EX_Rt,
  input  logic [4:0]  IF_ID_Rs,
  input  logic [4:0]  IF_ID_Rt,
  input  logic        Branch_Taken,
  input  logic        Mul_Start,
  output logic        PCWrite,
  output logic        IF_ID_Write,
  output logic        IF_ID_Flush,
  output logic        ID_EX_Bubble,
  output logic        Busy,
  output logic [15:0] Stall_Count
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MUL_WAIT = 2'd2
  } state_t;

  // The RUN cycle that starts a multiply is the first stall cycle.
  localparam logic [3:0] CNT_LOAD = 4'(MUL_CYCLES - 2);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       br_pend, br_pend_nxt;
  logic       lu;

  assign lu = ID_EX_MemRead && (ID_EX_Rt != 5'd0) &&
              ((ID_EX_Rt == IF_ID_Rs) || (ID_EX_Rt == IF_ID_Rt));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      cnt     <= 4'd0;
      br_pend <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      br_pend <= br_pend_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    br_pend_nxt  = br_pend;
    PCWrite      = 1'b1;
    IF_ID_Write  = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Bubble = 1'b0;
    Busy         = 1'b0;
    case (state)
      RUN: begin
        if (Branch_Taken) begin
          IF_ID_Flush  = 1'b1;
          ID_EX_Bubble = 1'b1;
          state_nxt    = FLUSH;
        end else if (Mul_Start) begin
          PCWrite      = 1'b0;
          IF_ID_Write  = 1'b0;
          ID_EX_Bubble = 1'b1;
          cnt_nxt      = CNT_LOAD;
          state_nxt    = MUL_WAIT;
        end else if (lu) begin
          PCWrite      = 1'b0;
          IF_ID_Write  = 1'b0;
          ID_EX_Bubble = 1'b1;
        end
      end
      FLUSH: begin
        IF_ID_Flush  = 1'b1;
        ID_EX_Bubble = 1'b1;
        state_nxt    = RUN;
      end
      MUL_WAIT: begin
        PCWrite      = 1'b0;
        IF_ID_Write  = 1'b0;
        ID_EX_Bubble = 1'b1;
        Busy         = 1'b1;
        // A branch seen on the exit cycle itself is honoured like a pending one.
        if (cnt == 4'd0) begin
          state_nxt   = (br_pend || Branch_Taken) ? FLUSH : RUN;
          br_pend_nxt = 1'b0;
        end else begin
          cnt_nxt     = cnt - 4'd1;
          br_pend_nxt = br_pend || Branch_Taken;
        end
      end
      default: begin
        state_nxt   = RUN;
        cnt_nxt     = 4'd0;
        br_pend_nxt = 1'b0;
      end
    endcase
    if (!rst_n) begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      IF_ID_Flush  = 1'b1;
      ID_EX_Bubble = 1'b1;
      Busy         = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Stall_Count <= 16'd0;
    end else if (!PCWrite && (Stall_Count != 16'hFFFF)) begin
      Stall_Count <= Stall_Count + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; output vector order is
// {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, Busy}.
module tb_hazard_ctrl;

  logic        clk;
  logic        rst_n;
  logic        ID_EX_MemRead;
  logic [4:0]  ID_EX_Rt;
  logic [4:0]  IF_ID_Rs;
  logic [4:0]  IF_ID_Rt;
  logic        Branch_Taken;
  logic        Mul_Start;
  logic        PCWrite;
  logic        IF_ID_Write;
  logic        IF_ID_Flush;
  logic        ID_EX_Bubble;
  logic        Busy;
  logic [15:0] Stall_Count;

  int checks = 0;
  int errors = 0;

  localparam logic [4:0] O_IDLE  = 5'b11000;
  localparam logic [4:0] O_FLUSH = 5'b11110;
  localparam logic [4:0] O_STALL = 5'b00010;
  localparam logic [4:0] O_MULW  = 5'b00011;
  localparam logic [4:0] O_RST   = 5'b00110;

  hazard_ctrl #(.MUL_CYCLES(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ID_EX_MemRead(ID_EX_MemRead),
    .ID_EX_Rt(ID_EX_Rt),
    .IF_ID_Rs(IF_ID_Rs),
    .IF_ID_Rt(IF_ID_Rt),
    .Branch_Taken(Branch_Taken),
    .Mul_Start(Mul_Start),
    .PCWrite(PCWrite),
    .IF_ID_Write(IF_ID_Write),
    .IF_ID_Flush(IF_ID_Flush),
    .ID_EX_Bubble(ID_EX_Bubble),
    .Busy(Busy),
    .Stall_Count(Stall_Count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [4:0] outs();
    return {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, Busy};
  endfunction

  // Apply one cycle of inputs at the falling edge; outputs settle 1 time unit later.
  task automatic drive(input logic mr, input logic [4:0] ert, input logic [4:0] rs,
                       input logic [4:0] rt, input logic br, input logic mul);
    @(negedge clk);
    ID_EX_MemRead = mr;
    ID_EX_Rt      = ert;
    IF_ID_Rs      = rs;
    IF_ID_Rt      = rt;
    Branch_Taken  = br;
    Mul_Start     = mul;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ID_EX_MemRead = 1'b0; ID_EX_Rt = 5'd0; IF_ID_Rs = 5'd0; IF_ID_Rt = 5'd0;
    Branch_Taken = 1'b0; Mul_Start = 1'b0;
    #1;
    checks++;
    if (outs() !== O_RST) begin
      errors++; $display("FAIL reset_outs got %b exp %b", outs(), O_RST);
    end
    checks++;
    if (Stall_Count !== 16'd0) begin
      errors++; $display("FAIL reset_cnt got %h exp 0000", Stall_Count);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (Stall_Count !== 16'd0 || outs() !== O_RST) begin
      errors++; $display("FAIL reset_hold got cnt=%h outs=%b exp cnt=0000 outs=%b", Stall_Count, outs(), O_RST);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (outs() !== O_IDLE) begin
      errors++; $display("FAIL reset_release got %b exp %b", outs(), O_IDLE);
    end
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (outs() !== O_IDLE || Stall_Count !== 16'd0) begin
      errors++; $display("FAIL idle got outs=%b cnt=%h exp outs=%b cnt=0000", outs(), Stall_Count, O_IDLE);
    end
  endtask

  task automatic test_load_use();
    drive(1, 5, 5, 0, 0, 0);
    checks++;
    if (outs() !== O_STALL) begin
      errors++; $display("FAIL lu_rs got %b exp %b", outs(), O_STALL);
    end
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (outs() !== O_IDLE || Stall_Count !== 16'd1) begin
      errors++; $display("FAIL lu_rs_after got outs=%b cnt=%0d exp outs=%b cnt=1", outs(), Stall_Count, O_IDLE);
    end
    drive(1, 7, 3, 7, 0, 0);
    checks++;
    if (outs() !== O_STALL) begin
      errors++; $display("FAIL lu_rt got %b exp %b", outs(), O_STALL);
    end
    drive(0, 7, 7, 7, 0, 0);
    checks++;
    if (outs() !== O_IDLE || Stall_Count !== 16'd2) begin
      errors++; $display("FAIL no_memread got outs=%b cnt=%0d exp outs=%b cnt=2", outs(), Stall_Count, O_IDLE);
    end
    drive(1, 9, 3, 4, 0, 0);
    checks++;
    if (outs() !== O_IDLE) begin
      errors++; $display("FAIL lu_nomatch got %b exp %b", outs(), O_IDLE);
    end
  endtask

  task automatic test_reg_zero();
    drive(1, 0, 0, 0, 0, 0);
    checks++;
    if (outs() !== O_IDLE) begin
      errors++; $display("FAIL reg_zero got %b exp %b", outs(), O_IDLE);
    end
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (Stall_Count !== 16'd2) begin
      errors++; $display("FAIL reg_zero_cnt got %0d exp 2", Stall_Count);
    end
  endtask

  task automatic test_branch();
    drive(0, 0, 0, 0, 1, 0);
    checks++;
    if (outs() !== O_FLUSH) begin
      errors++; $display("FAIL br_c0 got %b exp %b", outs(), O_FLUSH);
    end
    // Branch, multiply and load-use presented in FLUSH must be ignored.
    drive(1, 5, 5, 0, 1, 1);
    checks++;
    if (outs() !== O_FLUSH) begin
      errors++; $display("FAIL br_c1 got %b exp %b", outs(), O_FLUSH);
    end
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (outs() !== O_IDLE || Stall_Count !== 16'd2) begin
      errors++; $display("FAIL br_c2 got outs=%b cnt=%0d exp outs=%b cnt=2", outs(), Stall_Count, O_IDLE);
    end
  endtask

  task automatic test_priority();
    drive(1, 5, 5, 0, 1, 1);
    checks++;
    if (outs() !== O_FLUSH) begin
      errors++; $display("FAIL prio_br got %b exp %b", outs(), O_FLUSH);
    end
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 5, 5, 0, 0, 1);
    checks++;
    if (outs() !== O_STALL) begin
      errors++; $display("FAIL prio_mul got %b exp %b", outs(), O_STALL);
    end
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (outs() !== O_MULW) begin
      errors++; $display("FAIL prio_mul_busy got %b exp %b", outs(), O_MULW);
    end
    repeat (2) drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (outs() !== O_IDLE || Stall_Count !== 16'd6) begin
      errors++; $display("FAIL prio_end got outs=%b cnt=%0d exp outs=%b cnt=6", outs(), Stall_Count, O_IDLE);
    end
  endtask

  task automatic test_mul();
    logic [4:0] exp_o [5] = '{O_STALL, O_MULW, O_MULW, O_MULW, O_IDLE};
    for (int i = 0; i < 5; i++) begin
      if (i == 0)      drive(0, 0, 0, 0, 0, 1);
      else if (i == 2) drive(1, 5, 5, 5, 0, 0);
      else             drive(0, 0, 0, 0, 0, 0);
      checks++;
      if (outs() !== exp_o[i]) begin
        errors++; $display("FAIL mul_c%0d got %b exp %b", i, outs(), exp_o[i]);
      end
    end
    checks++;
    if (Stall_Count !== 16'd10) begin
      errors++; $display("FAIL mul_cnt got %0d exp 10", Stall_Count);
    end
  endtask

  task automatic test_deferred_branch();
    logic [4:0] exp_o [6] = '{O_STALL, O_MULW, O_MULW, O_MULW, O_FLUSH, O_IDLE};
    for (int i = 0; i < 6; i++) begin
      if (i == 0)      drive(0, 0, 0, 0, 0, 1);
      else if (i == 1) drive(0, 0, 0, 0, 1, 0);
      else             drive(0, 0, 0, 0, 0, 0);
      checks++;
      if (outs() !== exp_o[i]) begin
        errors++; $display("FAIL dbr_c%0d got %b exp %b", i, outs(), exp_o[i]);
      end
    end
    checks++;
    if (Stall_Count !== 16'd14) begin
      errors++; $display("FAIL dbr_cnt got %0d exp 14", Stall_Count);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0, 0, 0, 1);
      checks++;
      if (outs() !== ((i % 4 == 0) ? O_STALL : O_MULW)) begin
        errors++; $display("FAIL b2b_c%0d got %b exp %b", i, outs(), (i % 4 == 0) ? O_STALL : O_MULW);
      end
    end
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (outs() !== O_IDLE || Stall_Count !== 16'd22) begin
      errors++; $display("FAIL b2b_end got outs=%b cnt=%0d exp outs=%b cnt=22", outs(), Stall_Count, O_IDLE);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 70000; i++) drive(1, 3, 3, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (Stall_Count !== 16'hFFFF) begin
      errors++; $display("FAIL sat got %h exp FFFF", Stall_Count);
    end
    drive(1, 3, 0, 3, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (Stall_Count !== 16'hFFFF) begin
      errors++; $display("FAIL sat_hold got %h exp FFFF", Stall_Count);
    end
  endtask

  task automatic test_reset_mid_mul();
    drive(0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1, 0);
    checks++;
    if (outs() !== O_MULW) begin
      errors++; $display("FAIL rmm_busy got %b exp %b", outs(), O_MULW);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (outs() !== O_RST || Stall_Count !== 16'd0) begin
      errors++; $display("FAIL rmm_async got outs=%b cnt=%h exp outs=%b cnt=0000", outs(), Stall_Count, O_RST);
    end
    @(negedge clk);
    rst_n = 1'b1;
    Branch_Taken = 1'b0;
    #1;
    checks++;
    if (outs() !== O_IDLE) begin
      errors++; $display("FAIL rmm_release got %b exp %b", outs(), O_IDLE);
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0, 0);
      checks++;
      if (outs() !== O_IDLE || Stall_Count !== 16'd0) begin
        errors++; $display("FAIL rmm_after_c%0d got outs=%b cnt=%0d exp outs=%b cnt=0", i, outs(), Stall_Count, O_IDLE);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_reg_zero();
    test_branch();
    test_priority();
    test_mul();
    test_deferred_branch();
    test_back_to_back();
    test_saturation();
    test_reset_mid_mul();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
